// File: rtl/led_div_seq.sv
// ---------------------------------------------------------------------------
// led_div_seq
//   Upstream stage of the LED blink counter: produces the divider value and
//   its single-cycle write strobe for the counter's div_i/wren_i.
//
//   Follow mode (mode_i=0): debounces the raw divider div_i. Every settled
//   change that differs from the current div_o gives exactly one write.
//   Sweep mode  (mode_i=1): steps div_o through [DIV_MIN, DIV_MAX], advancing
//   once every BLINKS_PER_STEP rising edges of led_i.
//
//   Optional build macro LED_DIV_SEQ_PINGPONG_EN:
//     defined   - the sweep bounces between the bounds (direction flag,
//                 up on every entry to sweep mode).
//     undefined - the sweep wraps DIV_MAX -> DIV_MIN.
//
// Ports
//   clk100  in   1      system clock, single clock domain
//   rst     in   1      synchronous, active-high reset
//   div_i   in   DIV_W  raw divider from the block design; may glitch
//   mode_i  in   1      0 = follow, 1 = sweep
//   led_i   in   1      LED output of the downstream counter (clk100 domain)
//   div_o   out  DIV_W  divider to the counter; changes only with wren_o=1
//   wren_o  out  1      single-cycle write strobe
// ---------------------------------------------------------------------------
module led_div_seq #(
    parameter int DIV_W           = 5,
    parameter int DIV_RST         = 16,
    parameter int STABLE_CYC      = 1000,
    parameter int DIV_MIN         = 0,
    parameter int DIV_MAX         = 31,
    parameter int BLINKS_PER_STEP = 4
) (
    input  logic             clk100,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_i,
    input  logic             mode_i,
    input  logic             led_i,
    output logic [DIV_W-1:0] div_o,
    output logic             wren_o
);

    localparam int CNT_W    = $clog2(STABLE_CYC) + 1;
    localparam int BLINK_W  = $clog2(BLINKS_PER_STEP) + 1;
    localparam int NUM_VALS = 1 << DIV_W;

    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STABLE_CYC - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINKS_PER_STEP - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE    = DIV_W'(1);
    localparam logic [DIV_W-1:0]   RST_V      = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0]   MIN_V      = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0]   MAX_V      = DIV_W'(DIV_MAX);
`ifdef LED_DIV_SEQ_PINGPONG_EN
    localparam logic [DIV_W-1:0]   MIN_UP     = DIV_W'(DIV_MIN + 1);
    localparam logic [DIV_W-1:0]   MAX_DN     = DIV_W'(DIV_MAX - 1);
`endif

    // One bit per divider value, set where the value lies inside the sweep
    // range. A table lookup keeps the range test free of comparisons that
    // degenerate to constants when a bound sits at the edge of the type.
    function automatic logic [NUM_VALS-1:0] range_mask();
        logic [NUM_VALS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_VALS; i++) begin
            m[i] = (i >= DIV_MIN) && (i <= DIV_MAX);
        end
        return m;
    endfunction

    localparam logic [NUM_VALS-1:0] IN_RANGE = range_mask();

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WRITE,
        ST_SWEEP
    } state_t;

    state_t             state,  state_nxt;
    logic [DIV_W-1:0]   cand,   cand_nxt;
    logic [CNT_W-1:0]   cnt,    cnt_nxt;
    logic [BLINK_W-1:0] blink,  blink_nxt;
    logic               led_d;
    logic [DIV_W-1:0]   div_nxt;
    logic               wren_nxt;
    logic [DIV_W-1:0]   step_div;
    logic               led_rise;
`ifdef LED_DIV_SEQ_PINGPONG_EN
    logic               dir_up, dir_up_nxt, step_up;
`endif

    assign led_rise = led_i & ~led_d;

    // Next sweep value from the current divider.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        step_div = MIN_V;
`ifdef LED_DIV_SEQ_PINGPONG_EN
        step_up  = 1'b1;
        if (!IN_RANGE[div_o]) begin
            step_div = MIN_V;
            step_up  = 1'b1;
        end else if (dir_up) begin
            if (div_o == MAX_V) begin
                step_div = MAX_DN;
                step_up  = 1'b0;
            end else begin
                step_div = div_o + DIV_ONE;
                step_up  = 1'b1;
            end
        end else begin
            if (div_o == MIN_V) begin
                step_div = MIN_UP;
                step_up  = 1'b1;
            end else begin
                step_div = div_o - DIV_ONE;
                step_up  = 1'b0;
            end
        end
`else
        if (IN_RANGE[div_o] && (div_o != MAX_V)) begin
            step_div = div_o + DIV_ONE;
        end
`endif
    end

    // Next-state and output logic. A mode mismatch between mode_i and the
    // current state outranks everything else: it drops any pending write and
    // discards an LED edge seen on the same cycle.
    always_comb begin
        state_nxt  = state;
        cand_nxt   = cand;
        cnt_nxt    = cnt;
        blink_nxt  = blink;
        div_nxt    = div_o;
        wren_nxt   = 1'b0;
`ifdef LED_DIV_SEQ_PINGPONG_EN
        dir_up_nxt = dir_up;
`endif

        if (mode_i && (state != ST_SWEEP)) begin
            state_nxt  = ST_SWEEP;
            blink_nxt  = '0;
`ifdef LED_DIV_SEQ_PINGPONG_EN
            dir_up_nxt = 1'b1;
`endif
        end else if (!mode_i && (state == ST_SWEEP)) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (div_i != div_o) begin
                        cand_nxt  = div_i;
                        cnt_nxt   = CNT_ONE;
                        state_nxt = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (div_i != cand) begin
                        cand_nxt = div_i;
                        cnt_nxt  = CNT_ONE;
                    end else if (cnt == CNT_LAST) begin
                        // A glitch that settled back onto div_o needs no write.
                        state_nxt = (cand == div_o) ? ST_IDLE : ST_WRITE;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_WRITE: begin
                    div_nxt   = cand;
                    wren_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
                ST_SWEEP: begin
                    if (led_rise) begin
                        if (blink == BLINK_LAST) begin
                            blink_nxt  = '0;
                            div_nxt    = step_div;
                            wren_nxt   = 1'b1;
`ifdef LED_DIV_SEQ_PINGPONG_EN
                            dir_up_nxt = step_up;
`endif
                        end else begin
                            blink_nxt = blink + BLINK_ONE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk100) begin
        if (rst) begin
            state  <= ST_IDLE;
            cand   <= '0;
            cnt    <= '0;
            blink  <= '0;
            led_d  <= 1'b0;
            div_o  <= RST_V;
            wren_o <= 1'b0;
`ifdef LED_DIV_SEQ_PINGPONG_EN
            dir_up <= 1'b1;
`endif
        end else begin
            state  <= state_nxt;
            cand   <= cand_nxt;
            cnt    <= cnt_nxt;
            blink  <= blink_nxt;
            led_d  <= led_i;
            div_o  <= div_nxt;
            wren_o <= wren_nxt;
`ifdef LED_DIV_SEQ_PINGPONG_EN
            dir_up <= dir_up_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_led_div_seq.sv
// ---------------------------------------------------------------------------
// tb_led_div_seq
//   Self-checking bench for led_div_seq (STABLE_CYC=8, DIV_RST=16,
//   sweep range [2,4], 2 blinks per step). A behavioural model computes the
//   expected div_o/wren_o from the divider rules; a compare process checks
//   the DUT on every falling edge. Directed scenarios add literal checks,
//   followed by a randomized phase.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_div_seq;

    localparam int DIV_W      = 5;
    localparam int DIV_RST    = 16;
    localparam int STABLE_CYC = 8;
    localparam int DIV_MIN    = 2;
    localparam int DIV_MAX    = 4;
    localparam int BPS        = 2;

    logic             clk100 = 1'b0;
    logic             rst    = 1'b1;
    logic [DIV_W-1:0] div_i  = 5'd16;
    logic             mode_i = 1'b0;
    logic             led_i  = 1'b0;
    logic [DIV_W-1:0] div_o;
    logic             wren_o;

    int checks   = 0;
    int failures = 0;

    led_div_seq #(
        .DIV_W          (DIV_W),
        .DIV_RST        (DIV_RST),
        .STABLE_CYC     (STABLE_CYC),
        .DIV_MIN        (DIV_MIN),
        .DIV_MAX        (DIV_MAX),
        .BLINKS_PER_STEP(BPS)
    ) dut (
        .clk100(clk100),
        .rst   (rst),
        .div_i (div_i),
        .mode_i(mode_i),
        .led_i (led_i),
        .div_o (div_o),
        .wren_o(wren_o)
    );

    always #5 clk100 = ~clk100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Follow: a write happens on the edge after div_i has been sampled
    // STABLE_CYC times in a row with one value that differs from div_o. The
    // write edge itself and a mode-change edge do not sample div_i.
    // Sweep: every BPS-th LED rising edge steps div_o.
    int m_div, m_wren, m_run, m_run_val, m_pend, m_pend_val;
    int m_blink, m_mode, m_led_prev, m_up;
    bit m_valid = 1'b0;
    bit m_after_rst = 1'b0;

    always @(posedge clk100) begin
        if (rst) begin
            m_div = DIV_RST; m_wren = 0; m_run = 0; m_pend = 0;
            m_blink = 0; m_mode = 0; m_up = 1;
            m_valid = 1'b1; m_after_rst = 1'b1;
        end else begin
            m_after_rst = 1'b0;
            m_wren = 0;
            if (int'(mode_i) != m_mode) begin
                m_mode = int'(mode_i);
                m_run = 0; m_pend = 0; m_blink = 0; m_up = 1;
            end else if (m_mode == 0) begin
                if (m_pend != 0) begin
                    m_div = m_pend_val; m_wren = 1; m_pend = 0; m_run = 0;
                end else begin
                    if (m_run > 0 && int'(div_i) == m_run_val) m_run++;
                    else begin m_run_val = int'(div_i); m_run = 1; end
                    if (m_run == STABLE_CYC && m_run_val != m_div) begin
                        m_pend = 1; m_pend_val = m_run_val;
                    end
                end
            end else if (led_i && m_led_prev == 0) begin
                m_blink++;
                if (m_blink == BPS) begin
                    m_blink = 0;
                    m_wren  = 1;
                    if (m_div < DIV_MIN || m_div > DIV_MAX) begin
                        m_div = DIV_MIN; m_up = 1;
                    end
`ifdef LED_DIV_SEQ_PINGPONG_EN
                    else if (m_up != 0) begin
                        if (m_div == DIV_MAX) begin m_div = DIV_MAX - 1; m_up = 0; end
                        else m_div++;
                    end else begin
                        if (m_div == DIV_MIN) begin m_div = DIV_MIN + 1; m_up = 1; end
                        else m_div--;
                    end
`else
                    else if (m_div == DIV_MAX) m_div = DIV_MIN;
                    else m_div++;
`endif
                end
            end
        end
        m_led_prev = rst ? 0 : int'(led_i);
    end

    // ---------------- compare process ----------------
    int               pulses  = 0;
    logic [31:0]      wr_mask = '0;
    logic             prev_wren = 1'b0;
    logic [DIV_W-1:0] prev_div  = '0;

    always @(negedge clk100) begin
        if (m_valid) begin
            check("div_o", 32'(div_o), 32'(m_div));
            check("wren_o", 32'(wren_o), 32'(m_wren));
            if (!m_after_rst) begin
                check("wren_back_to_back", 32'(wren_o & prev_wren), 32'd0);
                check("div_change_without_wren", 32'((div_o != prev_div) && !wren_o), 32'd0);
            end
            if (wren_o) begin
                pulses++;
                wr_mask[div_o] = 1'b1;
            end
            prev_wren = wren_o;
            prev_div  = div_o;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk100);
        #1;
    endtask

    task automatic blink();
        led_i = 1'b1; tick(2);
        led_i = 1'b0; tick(2);
    endtask

    int hold;

    initial begin
        // Reset and idle with div_i equal to the reset divider.
        tick(3);
        check("reset_div", 32'(div_o), 32'd16);
        check("reset_wren", 32'(wren_o), 32'd0);
        rst = 1'b0;
        pulses = 0;
        tick(200);
        check("t1_pulses", 32'(pulses), 32'd0);
        check("t1_div", 32'(div_o), 32'd16);

        // Short excursion to 9 that returns to 16: no write.
        div_i = 5'd9;  tick(3);
        div_i = 5'd16; tick(30);
        check("t3b_pulses", 32'(pulses), 32'd0);

        // 16 -> 5: write exactly STABLE_CYC edges after the first sample.
        div_i = 5'd5;
        tick(8);
        check("t2_wren_early", 32'(wren_o), 32'd0);
        check("t2_div_early", 32'(div_o), 32'd16);
        tick(1);
        check("t2_wren", 32'(wren_o), 32'd1);
        check("t2_div", 32'(div_o), 32'd5);
        tick(1);
        check("t2_wren_clear", 32'(wren_o), 32'd0);
        tick(20);
        check("t2_pulses", 32'(pulses), 32'd1);

        // Back to reset value, then glitch 5 for 4 cycles, then 7 held.
        rst = 1'b1; div_i = 5'd16; tick(2);
        rst = 1'b0;
        check("t3_reset_div", 32'(div_o), 32'd16);
        pulses = 0; wr_mask = '0;
        div_i = 5'd5; tick(4);
        div_i = 5'd7; tick(8);
        check("t3_wren_early", 32'(wren_o), 32'd0);
        tick(1);
        check("t3_wren", 32'(wren_o), 32'd1);
        check("t3_div", 32'(div_o), 32'd7);
        tick(20);
        check("t3_pulses", 32'(pulses), 32'd1);
        check("t3_no_write_5", 32'(wr_mask[5]), 32'd0);

        // Reset while settling (cnt=5): pending write dropped.
        pulses = 0;
        div_i = 5'd12; tick(5);
        rst = 1'b1; tick(1);
        check("t5_div", 32'(div_o), 32'd16);
        check("t5_wren", 32'(wren_o), 32'd0);
        div_i = 5'd16; rst = 1'b0; tick(20);
        check("t5_pulses", 32'(pulses), 32'd0);

        // 0->1 during SETTLE aborts the write.
        div_i = 5'd3; tick(4);
        mode_i = 1'b1; tick(20);
        check("t6a_pulses", 32'(pulses), 32'd0);
        check("t6a_div", 32'(div_o), 32'd16);

        // Back to follow to load 3, then sweep.
        mode_i = 1'b0; tick(15);
        check("t4_setup_div", 32'(div_o), 32'd3);
        mode_i = 1'b1; tick(3);
        pulses = 0;
        blink();
        check("t4_one_blink", 32'(div_o), 32'd3);
        blink();
        check("t4_step1", 32'(div_o), 32'd4);
        check("t4_step1_pulses", 32'(pulses), 32'd1);
        blink(); blink();
`ifdef LED_DIV_SEQ_PINGPONG_EN
        check("t4_step2", 32'(div_o), 32'd3);
`else
        check("t4_step2", 32'(div_o), 32'd2);
`endif
        check("t4_step2_pulses", 32'(pulses), 32'd2);

        // Out-of-range divider (reset value 16) loads DIV_MIN on the first step.
        rst = 1'b1; tick(2);
        rst = 1'b0; tick(2);
        blink(); blink();
        check("oor_load_min", 32'(div_o), 32'd2);
        blink(); blink(); blink(); blink();
        check("sweep_to_max", 32'(div_o), 32'd4);

        // 1->0 with div_i=9, div_o=4: one write of 9 after 8+1 edges.
        pulses = 0;
        div_i = 5'd9; mode_i = 1'b0;
        tick(9);
        check("t6b_wren_early", 32'(wren_o), 32'd0);
        check("t6b_div_early", 32'(div_o), 32'd4);
        tick(1);
        check("t6b_wren", 32'(wren_o), 32'd1);
        check("t6b_div", 32'(div_o), 32'd9);
        tick(20);
        check("t6b_pulses", 32'(pulses), 32'd1);

        // Randomized phase, checked continuously by the compare process.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                div_i = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(DIV_MIN, DIV_MAX))
                                                    : 5'($urandom_range(0, 31));
                hold  = int'($urandom_range(1, 14));
            end else begin
                hold--;
            end
            if ($urandom_range(0, 79) == 0) mode_i = ~mode_i;
            if ($urandom_range(0, 2) == 0) led_i = ~led_i;
            rst = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
